alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Parametrised successor to the ALU-control decoder: decodes ALUOp/funct, executes the operation and returns a registered result with a valid/ready handshake.
- Adds HI/LO registers and iterative multi-cycle MULT/MULTU/DIV/DIVU, plus the new ops XOR, SLTU, ADDU/SUBU and signed-overflow detection.
- Sits in the EX stage; the pipeline stalls while in_ready is low.

Parameters:
- WIDTH, 32, datapath width; even, >= 8.
- HAS_MULDIV, 1, 0 removes HI/LO and the mul/div engine; funct 16/18/24-27 then decode as illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  unit can accept; a transfer occurs when in_valid && in_ready.
- alu_op  in  2  0=add (load/store), 1=sub (branch), 2=R-type (use func_code), 3=illegal.
- func_code  in  6  R-type funct field.
- a  in  WIDTH  operand rs.
- b  in  WIDTH  operand rt.
- out_valid  out  1  one-cycle pulse: result, flags and alu_ctl are valid.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow (add/sub only).
- illegal  out  1  undecodable op.
- alu_ctl  out  4  decoded control code, registered alongside result.

Behaviour:
- Reset: in_ready=1; out_valid, overflow and illegal=0; result, HI, LO and alu_ctl=0; zero=1; FSM=IDLE. Reset wins mid-operation: any in-flight mul/div is discarded and HI/LO are cleared.
- Decode for alu_op 0/1: add (ctl 2) / sub (ctl 6) with signed overflow.
- Decode for alu_op 2, by funct:
  - 32 add -> ctl 2, with overflow; 33 addu -> ctl 2, overflow=0.
  - 34 sub -> ctl 6, with overflow; 35 subu -> ctl 6, overflow=0.
  - 36 and -> 0; 37 or -> 1; 38 xor -> 13; 39 nor -> 12.
  - 42 slt -> 7 (signed); 43 sltu -> 8.
  - 16 mfhi -> 3, result=HI; 18 mflo -> 4, result=LO.
  - 24 mult -> 9; 25 multu -> 10; 26 div -> 11; 27 divu -> 14.
  - Anything else, or alu_op 3 -> ctl 15, result=0, illegal=1.
- Overflow is never a trap: the result is always written as the wrapped sum/difference.
- Single-cycle ops: accepted at edge E; out_valid is high in the cycle after E. in_ready stays 1, so back-to-back ops are accepted every cycle.
- FSM: IDLE -> MUL or DIV on accepting a mul/div op -> FIX -> IDLE.
  - MUL/DIV: exactly WIDTH cycles of radix-2 shift-add / restoring shift-subtract on operand magnitudes.
  - FIX: applies the sign correction and writes HI/LO.
  - out_valid pulses on the edge leaving FIX, i.e. WIDTH+2 edges after acceptance; result=LO and alu_ctl equals the mul/div code.
  - in_ready=0 from the acceptance edge until FIX completes, and is 1 in the out_valid cycle.
- Signed mult: HI:LO = full 2*WIDTH two's-complement product.
- Signed div: quotient truncates toward zero (LO); remainder takes the dividend's sign (HI).
- Divide by zero, signed or unsigned: LO = all ones, HI = a; latency unchanged.
- Signed div of most-negative by -1: LO = most-negative, HI = 0.
- in_valid while in_ready=0: ignored; inputs are not captured.
- An mfhi/mflo accepted in the out_valid cycle of a mul/div sees the new HI/LO.

Decomposition:
- Package alu_pkg holds:
  - localparams for ALUOp values, funct codes and the 4-bit ALU control codes (0,1,2,3,4,6,7,8,9,10,11,12,13,14,15);
  - an FSM state enum (IDLE, MUL, DIV, FIX).
- Sub-module alu_muldiv_seq: the iterative engine with start/done, signed flag, op select, and 2*WIDTH output; omitted when HAS_MULDIV=0.

Test Plan (WIDTH=32):
- add with alu_op=2, funct=32, a=7FFFFFFF, b=1 -> next cycle: out_valid=1, result=80000000, overflow=1, zero=0, alu_ctl=2. Same operands with funct=33 -> overflow=0.
- mult (funct 24), a=FFFFFFFD (-3), b=5 -> in_ready low 34 cycles, out_valid at edge 34; mfhi -> FFFFFFFF, mflo -> FFFFFFF1.
- div (funct 26), a=FFFFFFF9 (-7), b=2 -> LO=FFFFFFFD, HI=FFFFFFFF. divu, a=12345678, b=0 -> LO=FFFFFFFF, HI=12345678.
- sltu a=FFFFFFFF, b=1 -> result 0; slt with the same operands -> result 1. alu_op=2, funct=5 -> illegal=1, alu_ctl=15, result=0, zero=1.
- Start divu, pulse rst_n low at cycle 10 -> in_ready=1 and HI=LO=0 immediately. After release, single-cycle ops are accepted back-to-back with no stale out_valid.
- in_valid held high with an add during a mult -> add accepted only in the mult's out_valid cycle; its result appears the following cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execution unit: ALUOp values, funct codes,
// 4-bit ALU control codes and the mul/div sequencing state.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_RTYPE = 2'd2;
    localparam logic [1:0] ALUOP_ILL   = 2'd3;

    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_ADDU  = 6'd33;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SUBU  = 6'd35;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_XOR   = 6'd38;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLTU  = 6'd43;

    localparam logic [3:0] CTL_AND   = 4'd0;
    localparam logic [3:0] CTL_OR    = 4'd1;
    localparam logic [3:0] CTL_ADD   = 4'd2;
    localparam logic [3:0] CTL_MFHI  = 4'd3;
    localparam logic [3:0] CTL_MFLO  = 4'd4;
    localparam logic [3:0] CTL_SUB   = 4'd6;
    localparam logic [3:0] CTL_SLT   = 4'd7;
    localparam logic [3:0] CTL_SLTU  = 4'd8;
    localparam logic [3:0] CTL_MULT  = 4'd9;
    localparam logic [3:0] CTL_MULTU = 4'd10;
    localparam logic [3:0] CTL_DIV   = 4'd11;
    localparam logic [3:0] CTL_NOR   = 4'd12;
    localparam logic [3:0] CTL_XOR   = 4'd13;
    localparam logic [3:0] CTL_DIVU  = 4'd14;
    localparam logic [3:0] CTL_ILL   = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide engine on operand magnitudes: radix-2 shift-add or
// restoring shift-subtract, one bit per cycle; sign correction is left to the caller.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               div_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] res_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   rsh_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH:0]   hi_n_s;
    logic [WIDTH-1:0] lo_n_s;

    assign mag_a_s = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign mag_b_s = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    // One iteration step; hi holds the partial product or the running remainder
    always_comb begin
        hi_n_s = hi_q;
        lo_n_s = lo_q;
        add_s  = lo_q[0] ? (hi_q + {1'b0, dvs_q}) : hi_q;
        rsh_s  = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        sub_s  = rsh_s - {1'b0, dvs_q};
        if (div_q) begin
            if (!sub_s[WIDTH]) begin
                hi_n_s = sub_s;
                lo_n_s = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n_s = rsh_s;
                lo_n_s = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n_s = {1'b0, add_s[WIDTH:1]};
            lo_n_s = {add_s[0], lo_q[WIDTH-1:1]};
        end
    end

    // Load on start, then iterate exactly WIDTH times and hold until done is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= {CW{1'b0}};
            div_q  <= 1'b0;
            hi_q   <= {(WIDTH+1){1'b0}};
            lo_q   <= {WIDTH{1'b0}};
            dvs_q  <= {WIDTH{1'b0}};
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= {CW{1'b0}};
            div_q  <= div_i;
            hi_q   <= {(WIDTH+1){1'b0}};
            lo_q   <= mag_a_s;
            dvs_q  <= mag_b_s;
        end else if (busy_q) begin
            if (cnt_q != CNT_MAX) begin
                hi_q  <= hi_n_s;
                lo_q  <= lo_n_s;
                cnt_q <= cnt_q + CW'(1);
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done_o = busy_q && (cnt_q == CNT_MAX);
    assign res_o  = {hi_q[WIDTH-1:0], lo_q};

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: decodes ALUOp/funct, runs single-cycle ops directly and
// mul/div through the iterative engine, returning a registered result with valid/ready.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit HAS_MULDIV = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic [3:0]       alu_ctl
);

    localparam bit MD_EN = HAS_MULDIV;

    alu_state_e state_q, state_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;
    logic [3:0]       ctl_q, ctl_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] md_a_q, md_b_q;
    logic [3:0]       md_ctl_q;
    logic             md_signed_q, md_div_q;

    logic [WIDTH-1:0]   sum_s, diff_s, res_s;
    logic               add_ovf_s, sub_ovf_s, ovf_s, ill_s;
    logic [3:0]         ctl_s;
    logic               md_sel_s, md_start_s, md_done_s, md_div_s, md_signed_s;
    logic [2*WIDTH-1:0] md_res_s;
    logic [WIDTH-1:0]   md_hi_s, md_lo_s;

    assign sum_s       = a + b;
    assign diff_s      = a - b;
    assign add_ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
    assign md_div_s    = func_code[1];
    assign md_signed_s = ~func_code[0];

    // Operation decode and single-cycle datapath
    always_comb begin
        ctl_s    = CTL_ILL;
        res_s    = {WIDTH{1'b0}};
        ovf_s    = 1'b0;
        ill_s    = 1'b1;
        md_sel_s = 1'b0;
        case (alu_op)
            ALUOP_ADD: begin ctl_s = CTL_ADD; res_s = sum_s;  ovf_s = add_ovf_s; ill_s = 1'b0; end
            ALUOP_SUB: begin ctl_s = CTL_SUB; res_s = diff_s; ovf_s = sub_ovf_s; ill_s = 1'b0; end
            ALUOP_RTYPE: begin
                ill_s = 1'b0;
                case (func_code)
                    FN_ADD:  begin ctl_s = CTL_ADD;  res_s = sum_s;  ovf_s = add_ovf_s; end
                    FN_ADDU: begin ctl_s = CTL_ADD;  res_s = sum_s;  end
                    FN_SUB:  begin ctl_s = CTL_SUB;  res_s = diff_s; ovf_s = sub_ovf_s; end
                    FN_SUBU: begin ctl_s = CTL_SUB;  res_s = diff_s; end
                    FN_AND:  begin ctl_s = CTL_AND;  res_s = a & b; end
                    FN_OR:   begin ctl_s = CTL_OR;   res_s = a | b; end
                    FN_XOR:  begin ctl_s = CTL_XOR;  res_s = a ^ b; end
                    FN_NOR:  begin ctl_s = CTL_NOR;  res_s = ~(a | b); end
                    FN_SLT:  begin ctl_s = CTL_SLT;  res_s = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)}; end
                    FN_SLTU: begin ctl_s = CTL_SLTU; res_s = {{(WIDTH-1){1'b0}}, a < b}; end
                    FN_MFHI, FN_MFLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        if (MD_EN) begin
                            case (func_code)
                                FN_MFHI:  begin ctl_s = CTL_MFHI;  res_s = hi_q; end
                                FN_MFLO:  begin ctl_s = CTL_MFLO;  res_s = lo_q; end
                                FN_MULT:  begin ctl_s = CTL_MULT;  md_sel_s = 1'b1; end
                                FN_MULTU: begin ctl_s = CTL_MULTU; md_sel_s = 1'b1; end
                                FN_DIV:   begin ctl_s = CTL_DIV;   md_sel_s = 1'b1; end
                                FN_DIVU:  begin ctl_s = CTL_DIVU;  md_sel_s = 1'b1; end
                                default:  begin ctl_s = CTL_ILL;   ill_s = 1'b1; end
                            endcase
                        end else begin
                            ctl_s = CTL_ILL;
                            ill_s = 1'b1;
                        end
                    end
                    default: begin ctl_s = CTL_ILL; ill_s = 1'b1; end
                endcase
            end
            ALUOP_ILL: begin ctl_s = CTL_ILL; ill_s = 1'b1; end
            default:   begin ctl_s = CTL_ILL; ill_s = 1'b1; end
        endcase
    end

    generate
        if (HAS_MULDIV) begin : g_md
            alu_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
                .clk      (clk),
                .rst_n    (rst_n),
                .start_i  (md_start_s),
                .div_i    (md_div_s),
                .signed_i (md_signed_s),
                .a_i      (a),
                .b_i      (b),
                .done_o   (md_done_s),
                .res_o    (md_res_s)
            );
        end else begin : g_no_md
            assign md_done_s = 1'b0;
            assign md_res_s  = {(2*WIDTH){1'b0}};
        end
    endgenerate

    // Sign correction of the magnitude result; divide-by-zero bypasses it entirely
    always_comb begin
        md_hi_s = md_res_s[2*WIDTH-1:WIDTH];
        md_lo_s = md_res_s[WIDTH-1:0];
        if (!md_div_q) begin
            if (md_signed_q && (md_a_q[WIDTH-1] ^ md_b_q[WIDTH-1])) begin
                {md_hi_s, md_lo_s} = -md_res_s;
            end else begin
                {md_hi_s, md_lo_s} = md_res_s;
            end
        end else if (md_b_q == {WIDTH{1'b0}}) begin
            md_lo_s = {WIDTH{1'b1}};
            md_hi_s = md_a_q;
        end else begin
            md_lo_s = (md_signed_q && (md_a_q[WIDTH-1] ^ md_b_q[WIDTH-1]))
                      ? -md_res_s[WIDTH-1:0] : md_res_s[WIDTH-1:0];
            md_hi_s = (md_signed_q && md_a_q[WIDTH-1])
                      ? -md_res_s[2*WIDTH-1:WIDTH] : md_res_s[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state and output-register logic of the sequencing FSM
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;
        ctl_d       = ctl_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        md_start_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && md_sel_s) begin
                    md_start_s = 1'b1;
                    state_d    = md_div_s ? ST_DIV : ST_MUL;
                end else if (in_valid) begin
                    out_valid_d = 1'b1;
                    result_d    = res_s;
                    zero_d      = (res_s == {WIDTH{1'b0}});
                    ovf_d       = ovf_s;
                    ill_d       = ill_s;
                    ctl_d       = ctl_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_done_s) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FIX: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b1;
                hi_d        = md_hi_s;
                lo_d        = md_lo_s;
                result_d    = md_lo_s;
                zero_d      = (md_lo_s == {WIDTH{1'b0}});
                ovf_d       = 1'b0;
                ill_d       = 1'b0;
                ctl_d       = md_ctl_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, result and HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
            ctl_q       <= 4'd0;
            hi_q        <= {WIDTH{1'b0}};
            lo_q        <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
            ctl_q       <= ctl_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    // Operand signs and op code kept for the FIX step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_a_q      <= {WIDTH{1'b0}};
            md_b_q      <= {WIDTH{1'b0}};
            md_ctl_q    <= 4'd0;
            md_signed_q <= 1'b0;
            md_div_q    <= 1'b0;
        end else if (md_start_s) begin
            md_a_q      <= a;
            md_b_q      <= b;
            md_ctl_q    <= ctl_s;
            md_signed_q <= md_signed_s;
            md_div_q    <= md_div_s;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;
    assign alu_ctl   = ctl_q;

endmodule
